// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds a single 1-bit full adder one operand bit
// per clock (LSB first) and presents the WIDTH-bit sum and carry-out.

module adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a, op_b, res;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s, fa_cout;
   logic             last_bit;

   adder u_fa (
      .x    (op_a[0]),
      .y    (op_b[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands shift out LSB first; the sum bit enters at the top of res so
   // that after WIDTH shifts res holds the full result in natural order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               res   <= {fa_s, res[WIDTH-1:1]};
               op_a  <= {1'b0, op_a[WIDTH-1:1]};
               op_b  <= {1'b0, op_b[WIDTH-1:1]};
               carry <= fa_cout;
               cnt   <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum  <= {fa_s, res[WIDTH-1:1]};
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
